// File: rtl/scroll_scheduler.sv
// Terrain scroll scheduler: shifts a 1024x9 height RAM down by one entry per frame
// and arbitrates single-word draw-engine reads between passes.
module scroll_scheduler (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [8:0] new_y,
  input  logic       rd_req,
  input  logic [9:0] rd_addr,
  output logic       rd_ack,
  output logic [8:0] rd_data,
  output logic [9:0] ram_addr,
  output logic [8:0] ram_wdata,
  output logic       ram_wren,
  input  logic [8:0] ram_q,
  output logic       busy,
  output logic       done,
  output logic       overrun
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SH_RD    = 3'd1,
    SH_WR    = 3'd2,
    SH_LAST  = 3'd3,
    RD_ISSUE = 3'd4,
    RD_CAP   = 3'd5,
    RD_ACK   = 3'd6
  } state_t;

  state_t     state_r;
  state_t     next_state_s;
  logic [9:0] idx_r;
  logic [9:0] idx_s;
  logic [8:0] new_y_r;
  logic       load_y_s;
  logic       done_s;
  logic [9:0] ram_addr_s;
  logic       ram_wren_s;
  logic       busy_s;
  logic       rd_ack_s;

  // Next-state and index sequencing; a tick in IDLE wins over a pending read.
  always_comb begin
    next_state_s = state_r;
    idx_s        = idx_r;
    load_y_s     = 1'b0;
    done_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (frame_tick) begin
          next_state_s = SH_RD;
          idx_s        = 10'd0;
          load_y_s     = 1'b1;
        end else if (rd_req) begin
          next_state_s = RD_ISSUE;
        end else begin
          next_state_s = IDLE;
        end
      end
      SH_RD:    next_state_s = SH_WR;
      SH_WR: begin
        if (idx_r == 10'd1022) begin
          next_state_s = SH_LAST;
        end else begin
          idx_s        = idx_r + 10'd1;
          next_state_s = SH_RD;
        end
      end
      SH_LAST: begin
        next_state_s = IDLE;
        done_s       = 1'b1;
      end
      RD_ISSUE: next_state_s = RD_CAP;
      RD_CAP:   next_state_s = RD_ACK;
      RD_ACK:   next_state_s = IDLE;
      default:  next_state_s = IDLE;
    endcase
  end

  // Output look-ahead: decode from the next state so registered outputs line up with it.
  always_comb begin
    ram_addr_s = ram_addr;
    ram_wren_s = 1'b0;
    busy_s     = 1'b0;
    rd_ack_s   = 1'b0;
    case (next_state_s)
      SH_RD: begin
        ram_addr_s = idx_s + 10'd1;
        busy_s     = 1'b1;
      end
      SH_WR: begin
        ram_addr_s = idx_s;
        ram_wren_s = 1'b1;
        busy_s     = 1'b1;
      end
      SH_LAST: begin
        ram_addr_s = 10'd1023;
        ram_wren_s = 1'b1;
        busy_s     = 1'b1;
      end
      RD_ISSUE: ram_addr_s = rd_addr;
      RD_ACK:   rd_ack_s   = 1'b1;
      default:  ram_addr_s = ram_addr;
    endcase
  end

  // Write data: the word read one cycle earlier, or the latched new height on the last write.
  always_comb begin
    if (state_r == SH_LAST) begin
      ram_wdata = new_y_r;
    end else if (state_r == SH_WR) begin
      ram_wdata = ram_q;
    end else begin
      ram_wdata = 9'd0;
    end
  end

  // State, index and all registered outputs; reset aborts any pass in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r  <= IDLE;
      idx_r    <= 10'd0;
      new_y_r  <= 9'd0;
      ram_addr <= 10'd0;
      ram_wren <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rd_ack   <= 1'b0;
      rd_data  <= 9'd0;
      overrun  <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      idx_r    <= idx_s;
      new_y_r  <= load_y_s ? new_y : new_y_r;
      ram_addr <= ram_addr_s;
      ram_wren <= ram_wren_s;
      busy     <= busy_s;
      done     <= done_s;
      rd_ack   <= rd_ack_s;
      rd_data  <= (state_r == RD_CAP) ? ram_q : rd_data;
      overrun  <= overrun | (frame_tick & (state_r != IDLE));
    end
  end

endmodule

// File: tb/tb_scroll_scheduler.sv
// Self-checking bench for scroll_scheduler: behavioural 1024x9 RAM, reference
// height array, and a read scoreboard popped on each rd_ack.
module tb_scroll_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic [8:0] new_y;
  logic       rd_req;
  logic [9:0] rd_addr;
  logic       rd_ack;
  logic [8:0] rd_data;
  logic [9:0] ram_addr;
  logic [8:0] ram_wdata;
  logic       ram_wren;
  logic [8:0] ram_q;
  logic       busy;
  logic       done;
  logic       overrun;

  logic [8:0] mem [1024];
  logic [8:0] exp_mem [1024];
  logic       preload_all;
  logic       poke_en;
  logic [9:0] poke_addr;
  logic [8:0] poke_data;

  logic [8:0] rd_exp [$];
  logic [8:0] last_rd;
  int         n_vec = 0;
  int         n_err = 0;
  int         wren_cnt = 0;

  scroll_scheduler dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick), .new_y(new_y),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wren(ram_wren), .ram_q(ram_q),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clock = ~clock;

  // Synchronous RAM with one-cycle read latency, plus bench-side loading ports.
  always @(posedge clock) begin
    if (preload_all) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 9'(i);
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_q <= mem[ram_addr];
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Sample the current cycle: count writes and score any read acknowledge.
  task automatic observe();
    logic [8:0] want;
    if (ram_wren === 1'b1) wren_cnt++;
    if (rd_ack === 1'b1) begin
      check_value("rd_pending", 32'(rd_exp.size() != 0), 32'd1);
      if (rd_exp.size() != 0) begin
        want = rd_exp.pop_front();
        check_value("rd_data", 32'(rd_data), 32'(want));
        last_rd = want;
      end
    end
  endtask

  task automatic model_init();
    for (int i = 0; i < 1024; i++) exp_mem[i] = 9'(i);
  endtask

  task automatic model_shift(input logic [8:0] ny);
    for (int i = 0; i < 1023; i++) exp_mem[i] = exp_mem[i + 1];
    exp_mem[1023] = ny;
  endtask

  task automatic load_all();
    preload_all = 1'b1;
    step();
    preload_all = 1'b0;
    model_init();
  endtask

  task automatic poke(input logic [9:0] a, input logic [8:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    step();
    poke_en = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic compare_mem(input string tag);
    int bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) bad++;
    check_value({tag, "_bad_entries"}, 32'(bad), 32'd0);
    check_value({tag, "_entry1023"}, 32'(mem[1023]), 32'(exp_mem[1023]));
  endtask

  // One frame: optional simultaneous read of entry 5, second tick, or mid-pass reset.
  task automatic do_pass(input logic [8:0] ny, input int tick2_at, input int rst_at,
                         input logic with_rd, output int done_at, output int busy_n,
                         output int ack_at);
    frame_tick = 1'b1;
    new_y      = ny;
    if (rst_at == 0) model_shift(ny);
    if (with_rd) begin
      rd_req  = 1'b1;
      rd_addr = 10'd5;
      rd_exp.push_back(exp_mem[5]);
    end
    step();
    frame_tick = 1'b0;
    done_at = -1; ack_at = -1; busy_n = 0;
    for (int k = 1; k <= 2200; k++) begin
      observe();
      if (busy === 1'b1) busy_n++;
      if (done === 1'b1 && done_at < 0) done_at = k;
      if (rd_ack === 1'b1 && ack_at < 0) begin
        ack_at = k;
        rd_req = 1'b0;
      end
      if (rst_at != 0 && k == rst_at + 1) begin
        check_value("abort_busy", 32'(busy), 32'd0);
        check_value("abort_wren", 32'(ram_wren), 32'd0);
        check_value("abort_overrun", 32'(overrun), 32'd0);
      end
      frame_tick = (k == tick2_at);
      reset      = !(rst_at != 0 && k == rst_at);
      step();
    end
    frame_tick = 1'b0;
    reset      = 1'b1;
  endtask

  task automatic do_read(input logic [9:0] a, input int n);
    int acks = 0;
    int first = -1;
    int last = -1;
    int w0 = wren_cnt;
    rd_req  = 1'b1;
    rd_addr = a;
    for (int j = 0; j < n; j++) rd_exp.push_back(exp_mem[a]);
    step();
    for (int k = 1; k <= 40; k++) begin
      observe();
      if (rd_ack === 1'b1) begin
        acks++;
        if (first < 0) first = k;
        last = k;
        if (acks == n) begin
          rd_req = 1'b0;
          break;
        end
      end
      step();
    end
    rd_req = 1'b0;
    step();
    check_value("rd_ack_cycle", 32'(first), 32'd3);
    check_value("rd_last_ack", 32'(last), 32'(3 + 4 * (n - 1)));
    check_value("rd_no_wren", 32'(wren_cnt - w0), 32'd0);
  endtask

  initial begin
    int d_at, b_n, a_at, w0;
    reset = 1'b0; frame_tick = 1'b0; new_y = 9'd0; rd_req = 1'b0; rd_addr = 10'd0;
    preload_all = 1'b0; poke_en = 1'b0; poke_addr = 10'd0; poke_data = 9'd0;
    last_rd = 9'd0;
    repeat (2) @(posedge clock);
    #1;
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_rd_ack", 32'(rd_ack), 32'd0);
    check_value("rst_rd_data", 32'(rd_data), 32'd0);
    check_value("rst_overrun", 32'(overrun), 32'd0);
    check_value("rst_wren", 32'(ram_wren), 32'd0);
    check_value("rst_addr", 32'(ram_addr), 32'd0);
    check_value("rst_wdata", 32'(ram_wdata), 32'd0);
    reset = 1'b1;
    step();

    // Full pass over an identity-loaded RAM.
    load_all();
    w0 = wren_cnt;
    do_pass(9'h1FF, 0, 0, 1'b0, d_at, b_n, a_at);
    check_value("pass_done_cycle", 32'(d_at), 32'd2048);
    check_value("pass_busy_cycles", 32'(b_n), 32'd2047);
    check_value("pass_wren_cycles", 32'(wren_cnt - w0), 32'd1024);
    compare_mem("pass1");

    // Idle reads, including a held request that issues twice.
    poke(10'd5, 9'h0AA);
    do_read(10'd5, 1);
    do_read(10'd1023, 1);
    do_read(10'd0, 1);
    do_read(10'd700, 1);
    do_read(10'd7, 2);
    repeat (5) step();
    check_value("rd_data_hold", 32'(rd_data), 32'(last_rd));

    // Tick and read together: the pass runs first, the read sees shifted data.
    w0 = wren_cnt;
    do_pass(9'h055, 0, 0, 1'b1, d_at, b_n, a_at);
    check_value("both_done_cycle", 32'(d_at), 32'd2048);
    check_value("both_ack_cycle", 32'(a_at), 32'd2051);
    check_value("both_wren_cycles", 32'(wren_cnt - w0), 32'd1024);
    check_value("both_rd_drained", 32'(rd_exp.size()), 32'd0);
    compare_mem("pass2");

    // Second tick mid-pass is dropped and flagged.
    check_value("overrun_clear", 32'(overrun), 32'd0);
    w0 = wren_cnt;
    do_pass(9'h123, 100, 0, 1'b0, d_at, b_n, a_at);
    check_value("ovr_flag", 32'(overrun), 32'd1);
    check_value("ovr_done_cycle", 32'(d_at), 32'd2048);
    check_value("ovr_busy_cycles", 32'(b_n), 32'd2047);
    check_value("ovr_wren_cycles", 32'(wren_cnt - w0), 32'd1024);
    compare_mem("pass3");

    // Reset mid-pass aborts without done; the next pass is complete.
    do_pass(9'h0F0, 0, 500, 1'b0, d_at, b_n, a_at);
    check_value("abort_no_done", 32'(d_at), 32'hFFFF_FFFF);
    load_all();
    w0 = wren_cnt;
    do_pass(9'h0F0, 0, 0, 1'b0, d_at, b_n, a_at);
    check_value("post_done_cycle", 32'(d_at), 32'd2048);
    check_value("post_busy_cycles", 32'(b_n), 32'd2047);
    check_value("post_wren_cycles", 32'(wren_cnt - w0), 32'd1024);
    compare_mem("pass4");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/scroll_scheduler.md
SCROLL_SCHEDULER -- requirements
Module: scroll_scheduler

Interface
REQ-001 Parameters: none; depth fixed at 1024 entries, data width 9.
REQ-002 clock  in  1  single system clock; all state changes on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 frame_tick  in  1  one-cycle pulse; requests one scroll pass.
REQ-005 new_y  in  9  height inserted at entry 1023; sampled on the accepted frame_tick.
REQ-006 rd_req  in  1  draw-engine read request; held high until rd_ack.
REQ-007 rd_addr  in  10  draw-engine read address; sampled with rd_req.
REQ-008 rd_ack  out  1  one-cycle pulse; rd_data valid in the same cycle.
REQ-009 rd_data  out  9  registered read result, held until the next read.
REQ-010 ram_addr  out  10  address to the 1024x9 terrain RAM.
REQ-011 ram_wdata  out  9  RAM write data.
REQ-012 ram_wren  out  1  RAM write enable.
REQ-013 ram_q  in  9  RAM read data, valid the cycle after ram_addr is presented.
REQ-014 busy  out  1  high while a scroll pass is in progress.
REQ-015 done  out  1  one-cycle pulse when a scroll pass completes.
REQ-016 overrun  out  1  sticky flag: frame_tick arrived while busy.

Function
REQ-017 States: IDLE, SH_RD, SH_WR, SH_LAST, RD_ISSUE, RD_CAP, RD_ACK.
REQ-018 Scroll semantics: entry[i] <= old entry[i+1] for i = 0..1022; entry[1023] <= latched new_y.
REQ-019 IDLE + frame_tick: latch new_y, index i=0, go to SH_RD; frame_tick has priority over a simultaneous rd_req.
REQ-020 SH_RD: ram_addr=i+1, ram_wren=0; next state SH_WR.
REQ-021 SH_WR: ram_addr=i, ram_wren=1, ram_wdata=ram_q (combinational path); if i=1022 go to SH_LAST, else i=i+1 and go to SH_RD.
REQ-022 SH_LAST: ram_addr=1023, ram_wren=1, ram_wdata=latched new_y; next state IDLE with done=1 for one cycle.
REQ-023 Timing: tick sampled at edge 0; busy high in cycles 1..2047; done high in cycle 2048; exactly 1024 write cycles per pass.
REQ-024 All outputs except ram_wdata are registered; ram_wren is low in every state other than SH_WR and SH_LAST.
REQ-025 IDLE + rd_req without frame_tick: latch rd_addr and go to RD_ISSUE (ram_addr = latched address), then RD_CAP (rd_data <= ram_q), then RD_ACK (rd_ack=1), then IDLE.
REQ-026 Read latency: rd_req sampled at edge 0; rd_ack high in cycle 3.
REQ-027 rd_req is sampled only in IDLE; if rd_req is still high in the IDLE cycle after RD_ACK, it is a new request.
REQ-028 frame_tick while busy or in a read state: ignored, no pass queued, overrun set to 1; overrun is cleared only by reset.
REQ-029 frame_tick in the IDLE cycle where done=1: accepted normally.
REQ-030 Index arithmetic: 10-bit, no wrap; i never exceeds 1022 in SH_RD/SH_WR.

Reset
REQ-031 When reset=0 at an edge: state=IDLE and ram_addr, ram_wdata latch, ram_wren, busy, done, rd_ack, rd_data and overrun are all 0.
REQ-032 Reset mid-pass aborts immediately; ram_wren=0 from the next cycle; RAM contents are left partial; no done pulse.

Verification
REQ-033 Hold reset low for 2 cycles -> all outputs 0, state IDLE.
REQ-034 Preload entry[i]=i[8:0]; frame_tick with new_y=9'h1FF -> done exactly 2048 cycles later; entry[i]=(i+1)[8:0] for i<1023; entry[1023]=9'h1FF; 1024 ram_wren cycles.
REQ-035 Idle with entry[5]=9'h0AA; rd_req with rd_addr=5 -> rd_ack in cycle 3, rd_data=9'h0AA, no ram_wren.
REQ-036 frame_tick and rd_req(addr 5) in the same cycle -> full pass first; the read is served after done and returns the post-shift entry[5] (old entry[6]).
REQ-037 Second frame_tick at cycle 100 of a pass -> overrun=1, pass still ends at cycle 2048, only one pass executed.
REQ-038 Reset low at cycle 500 of a pass -> next cycle busy=0, ram_wren=0; a following frame_tick runs a complete 2048-cycle pass.
